// File: rtl/uart_pkg.sv
// Shared state type and sizing helpers for the parametrised UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } uart_rx_state_t;

  // Majority-vote samples sit one tick either side of the bit-period midpoint.
  localparam int unsigned SAMPLE_EARLY_OFS = 1;
  localparam int unsigned SAMPLE_LATE_OFS  = 1;

  function automatic int unsigned tick_cnt_w(input int unsigned os);
    return $clog2(os);
  endfunction

  function automatic int unsigned bit_cnt_w(input int unsigned db);
    return $clog2(db + 1);
  endfunction

  function automatic int unsigned mid_tick(input int unsigned os);
    return os / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser (preset high) and 3-sample majority voter for uart_receiver_param.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int TW         = tick_cnt_w(OVERSAMPLE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_tick,
  input  logic          i_rx,
  input  logic [TW-1:0] i_tick_cnt,
  output logic          o_rx_sync,
  output logic          o_bit
);

  localparam logic [TW-1:0] T_S0 = TW'(mid_tick(OVERSAMPLE) - SAMPLE_EARLY_OFS);
  localparam logic [TW-1:0] T_S1 = TW'(mid_tick(OVERSAMPLE));

  logic r_meta;
  logic r_sync;
  logic r_s0;
  logic r_s1;

  // Two-flop synchroniser for the asynchronous serial line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_rx;
      r_sync <= r_meta;
    end
  end

  // Capture the first two vote samples; the third is the live synchronised line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s0 <= 1'b1;
      r_s1 <= 1'b1;
    end else if (i_tick) begin
      if (i_tick_cnt == T_S0) r_s0 <= r_sync;
      if (i_tick_cnt == T_S1) r_s1 <= r_sync;
    end
  end

  assign o_rx_sync = r_sync;
  assign o_bit     = (r_s0 & r_s1) | (r_s0 & r_sync) | (r_s1 & r_sync);

endmodule

// File: rtl/uart_receiver_param.sv
// Parametrised UART receiver with valid/ready output register.
// Optional parity bit is built in when UART_RX_PARITY_EN is defined.
module uart_receiver_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_rate_signal,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid_data,
  input  logic                 data_ready,
  output logic                 framing_error,
  output logic                 parity_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = tick_cnt_w(OVERSAMPLE);
  localparam int BW = bit_cnt_w(DATA_BITS);
  localparam logic [TW-1:0] T_START_SMP = TW'(mid_tick(OVERSAMPLE) - SAMPLE_EARLY_OFS);
  localparam logic [TW-1:0] T_DECIDE    = TW'(mid_tick(OVERSAMPLE) + SAMPLE_LATE_OFS);
  localparam logic [TW-1:0] T_LAST      = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_DATA_END  = BW'(DATA_BITS);
  localparam logic [BW-1:0] B_LAST_STOP = BW'(STOP_BITS - 1);

  uart_rx_state_t       r_state;
  logic [TW-1:0]        r_tick_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_ferr;
  logic                 r_busy;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_framing_error;
  logic                 r_parity_error;
  logic                 r_overrun;
  logic                 w_rx_sync;
  logic                 w_bit;
  logic                 w_complete;
  logic                 w_frame_ferr;
  logic                 w_frame_perr;

  uart_rx_sampler #(
    .OVERSAMPLE (OVERSAMPLE),
    .TW         (TW)
  ) u_sampler (
    .clk        (clk),
    .reset      (reset),
    .i_tick     (baud_rate_signal),
    .i_rx       (uart_rx),
    .i_tick_cnt (r_tick_cnt),
    .o_rx_sync  (w_rx_sync),
    .o_bit      (w_bit)
  );

`ifdef UART_RX_PARITY_EN
  logic r_perr;
  assign w_frame_perr = r_perr;
`else
  assign w_frame_perr = 1'b0;
`endif

  // The frame ends on the vote tick of the last stop bit, not at bit end.
  assign w_complete   = baud_rate_signal && (r_state == ST_STOP) &&
                        (r_tick_cnt == T_DECIDE) && (r_bit_cnt == B_LAST_STOP);
  assign w_frame_ferr = r_ferr | ~w_bit;

  // Receive FSM; advances only on baud ticks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_ferr     <= 1'b0;
      r_busy     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr     <= 1'b0;
`endif
    end else if (baud_rate_signal) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_rx_sync) begin
            r_state    <= ST_START;
            r_tick_cnt <= '0;
            r_ferr     <= 1'b0;
            r_busy     <= 1'b1;
`ifdef UART_RX_PARITY_EN
            r_perr     <= 1'b0;
`endif
          end
        end
        ST_START: begin
          if ((r_tick_cnt == T_START_SMP) && w_rx_sync) begin
            r_state    <= ST_IDLE;
            r_tick_cnt <= '0;
            r_busy     <= 1'b0;
          end else if (r_tick_cnt == T_LAST) begin
            r_state    <= ST_DATA;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
          end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (r_tick_cnt == T_DECIDE) begin
            r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          if (r_tick_cnt == T_LAST) begin
            r_tick_cnt <= '0;
            if (r_bit_cnt == B_DATA_END) begin
              r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
              r_state   <= ST_PARITY;
`else
              r_state   <= ST_STOP;
`endif
            end
          end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (r_tick_cnt == T_DECIDE) begin
            r_perr <= w_bit ^ (^r_shift) ^ 1'(PARITY_ODD);
          end
          if (r_tick_cnt == T_LAST) begin
            r_state    <= ST_STOP;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
          end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if ((r_tick_cnt == T_DECIDE) && (r_bit_cnt == B_LAST_STOP)) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_state    <= w_frame_ferr ? ST_WAIT_IDLE : ST_IDLE;
            r_busy     <= w_frame_ferr;
          end else begin
            if (r_tick_cnt == T_DECIDE) r_ferr <= w_frame_ferr;
            if (r_tick_cnt == T_LAST) begin
              r_tick_cnt <= '0;
              r_bit_cnt  <= r_bit_cnt + 1'b1;
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (w_rx_sync) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_tick_cnt <= '0;
          r_bit_cnt  <= '0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  // Output register: a completing frame either loads or is dropped as overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data          <= '0;
      r_valid         <= 1'b0;
      r_framing_error <= 1'b0;
      r_parity_error  <= 1'b0;
      r_overrun       <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_complete) begin
        if (!r_valid || data_ready) begin
          r_data          <= r_shift;
          r_framing_error <= w_frame_ferr;
          r_parity_error  <= w_frame_perr;
          r_valid         <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && data_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data          = r_data;
  assign valid_data    = r_valid;
  assign framing_error = r_framing_error;
  assign parity_error  = r_parity_error;
  assign overrun       = r_overrun;
  assign busy          = r_busy;

endmodule

// File: tb/tb_uart_receiver_param.sv
// Scoreboard bench for uart_receiver_param (8 data bits, 16x oversample, 1 stop bit).
module tb_uart_receiver_param;

`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  // Clock edge (counted from frame start) carrying the last stop-bit vote.
  localparam int COMP_EDGE = 29 + 16 * (8 + PAR_BITS);

  typedef struct {
    logic [7:0] data;
    logic       fe;
    logic       pe;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       baud_rate_signal;
  logic       uart_rx;
  logic [7:0] data;
  logic       valid_data;
  logic       data_ready;
  logic       framing_error;
  logic       parity_error;
  logic       overrun;
  logic       busy;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ovr_cnt  = 0;
  logic prev_valid = 1'b0;

  uart_receiver_param #(
    .DATA_BITS  (8),
    .OVERSAMPLE (16),
    .STOP_BITS  (1),
    .PARITY_ODD (0)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .baud_rate_signal (baud_rate_signal),
    .uart_rx          (uart_rx),
    .data             (data),
    .valid_data       (valid_data),
    .data_ready       (data_ready),
    .framing_error    (framing_error),
    .parity_error     (parity_error),
    .overrun          (overrun),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic fe, input logic pe);
    exp_t e;
    e.data = d;
    e.fe   = fe;
    e.pe   = pe;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; each bit lasts 16 clocks.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_v);
    uart_rx = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      repeat (16) @(posedge clk);
      #1;
    end
`ifdef UART_RX_PARITY_EN
    uart_rx = par;
    repeat (16) @(posedge clk);
    #1;
`else
    uart_rx = par & 1'b0;
`endif
    uart_rx = stop_v;
    repeat (16) @(posedge clk);
    #1;
    uart_rx = 1'b1;
  endtask

  // Monitor: compares each accepted word against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      prev_valid = 1'b0;
    end else begin
      if (valid_data && !prev_valid) begin
        n_checks++;
        if (busy !== framing_error) begin
          n_fail++;
          $display("FAIL busy_at_load: got %0b expected %0b", busy, framing_error);
        end
      end
      if (valid_data && data_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_word: got %0h expected none", data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (data !== e.data || framing_error !== e.fe || parity_error !== e.pe) begin
            n_fail++;
            $display("FAIL word: got %0h fe=%0b pe=%0b expected %0h fe=%0b pe=%0b",
                     data, framing_error, parity_error, e.data, e.fe, e.pe);
          end
        end
      end
      if (overrun) ovr_cnt++;
      prev_valid = valid_data;
    end
  end

  initial begin
    int waited;
    reset            = 1'b0;
    uart_rx          = 1'b1;
    data_ready       = 1'b1;
    baud_rate_signal = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {19'd0, data, valid_data, framing_error, parity_error, overrun, busy}, 32'd0);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Basic frame, consumer always ready.
    push(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, ^8'hA5, 1'b1);
    check("t1_valid_one_clk", {31'd0, valid_data}, 32'd0);
    check("t1_busy_idle", {31'd0, busy}, 32'd0);
    repeat (16) @(posedge clk);
    #1;

    // Start-bit glitch then a real frame.
    uart_rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    repeat (24) @(posedge clk);
    #1;
    check("t2_false_start", {30'd0, valid_data, busy}, 32'd0);
    push(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, ^8'h3C, 1'b1);
    repeat (16) @(posedge clk);
    #1;

    // Back-to-back with consumer stalled: second word dropped.
    data_ready = 1'b0;
    push(8'h11, 1'b0, 1'b0);
    send_frame(8'h11, ^8'h11, 1'b1);
    send_frame(8'h22, ^8'h22, 1'b1);
    check("t3_held_valid", {31'd0, valid_data}, 32'd1);
    check("t3_held_data", {24'd0, data}, 32'h11);
    check("t3_overrun_once", ovr_cnt, 32'd1);
    data_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t3_valid_cleared", {31'd0, valid_data}, 32'd0);

    // Accept on the completing clk: new word loads, no overrun.
    data_ready = 1'b0;
    push(8'h11, 1'b0, 1'b0);
    send_frame(8'h11, ^8'h11, 1'b1);
    push(8'h22, 1'b0, 1'b0);
    fork
      send_frame(8'h22, ^8'h22, 1'b1);
      begin
        repeat (COMP_EDGE - 1) @(posedge clk);
        #1;
        data_ready = 1'b1;
        @(posedge clk);
        #1;
        data_ready = 1'b0;
      end
    join
    check("t3b_valid_kept", {31'd0, valid_data}, 32'd1);
    check("t3b_new_data", {24'd0, data}, 32'h22);
    check("t3b_no_overrun", ovr_cnt, 32'd1);
    data_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t3b_valid_cleared", {31'd0, valid_data}, 32'd0);

    // Break: low stop bit then line held low for 40 bit-times.
    push(8'h00, 1'b1, 1'b0);
    send_frame(8'h00, 1'b0, 1'b0);
    uart_rx = 1'b0;
    repeat (20 * 16) @(posedge clk);
    #1;
    check("t4_wait_idle_busy", {31'd0, busy}, 32'd1);
    check("t4_single_word", {31'd0, valid_data}, 32'd0);
    repeat (20 * 16) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    repeat (32) @(posedge clk);
    #1;
    check("t4_rearmed", {31'd0, busy}, 32'd0);
    push(8'h55, 1'b0, 1'b0);
    send_frame(8'h55, ^8'h55, 1'b1);
    repeat (16) @(posedge clk);
    #1;

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity expects a 1.
    push(8'h07, 1'b0, 1'b1);
    send_frame(8'h07, 1'b0, 1'b1);
    push(8'h07, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (16) @(posedge clk);
    #1;
`endif

    // Reset mid-frame, with an undelivered word pending.
    data_ready = 1'b0;
    send_frame(8'h5A, ^8'h5A, 1'b1);
    check("t6_pending", {31'd0, valid_data}, 32'd1);
    uart_rx = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    repeat (48) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t6_reset_outputs", {19'd0, data, valid_data, framing_error, parity_error, overrun, busy}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (32) @(posedge clk);
    #1;
    check("t6_no_partial", {30'd0, valid_data, busy}, 32'd0);
    data_ready = 1'b1;
    push(8'h81, 1'b0, 1'b0);
    send_frame(8'h81, ^8'h81, 1'b1);

    waited = 0;
    while (exp_q.size() != 0 && waited < 2000) begin
      @(posedge clk);
      waited++;
    end
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    check("overrun_total", ovr_cnt, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_receiver_param.md
Name: uart_receiver_param

Overview:
Parametrised next-generation UART receiver.
- Oversamples the serial line on a baud-rate tick enable and recovers data by majority vote.
- Supports configurable word length, stop bits and optional parity.
- Presents each frame on a valid/ready output register with error flags.
- Sits between the pad-side `uart_rx` line and the byte-consuming logic; shares the baud tick generator with the transmitter.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, LSB first
OVERSAMPLE, 16, baud_rate_signal ticks per bit period, even, >=8
STOP_BITS, 1, stop bits checked per frame, 1 or 2
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (used only with UART_RX_PARITY_EN)

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-low reset
baud_rate_signal  input  1  one-clk-wide tick at OVERSAMPLE x baud rate
uart_rx  input  1  asynchronous serial line, idle high
data  output  DATA_BITS  received word; stable while valid_data=1
valid_data  output  1  word available; held until accepted
data_ready  input  1  consumer accepts when valid_data and data_ready are high on a clk edge
framing_error  output  1  qualifies data: a stop bit sampled low
parity_error  output  1  qualifies data: parity mismatch (0 when parity compiled out)
overrun  output  1  one-clk pulse: completed frame dropped because output still full
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (reset=0, asynchronous): FSM to IDLE, counters 0, synchroniser preset to 1; data=0, valid_data=0, framing_error=0, parity_error=0, overrun=0, busy=0.
- Reset mid-frame aborts the frame immediately; nothing is delivered.
- uart_rx passes through a 2-flop synchroniser (preset 1) before any use.
- All FSM/counter progress happens only on clks with baud_rate_signal=1; between ticks state holds.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: synchronised line low on a tick -> START, tick counter cleared.
- START:
  - At tick OVERSAMPLE/2-1 the line is sampled.
  - Line high -> false start, back to IDLE, no flags.
  - Line low -> DATA, bit counter 0, tick counter 0.
- Bit sampling (DATA/PARITY/STOP):
  - Bit value = majority of samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of the bit period.
  - Bit period ends at tick OVERSAMPLE-1.
- DATA: shifts bits in LSB first; after DATA_BITS bits -> PARITY if compiled in, else STOP.
- STOP:
  - Checks STOP_BITS bits.
  - Any stop bit low -> framing_error for this frame.
  - Frame completes on the majority-decision tick of the last stop bit; next-state IDLE is not delayed to bit end.
  - Framing error -> WAIT_IDLE instead of IDLE.
- WAIT_IDLE: stays until the synchronised line is high on a tick, then IDLE. Break handling: all-zero data with low stop gives exactly one delivered frame, then re-arm.
- Output handshake:
  - On frame completion, the output register loads data/framing_error/parity_error next clk, and valid_data=1.
  - Latency is 1 clk after the completing tick.
  - valid_data clears on the clk where valid_data and data_ready are both high.
- Simultaneous events:
  - Frame completion on the same clk as an accepting handshake -> new word loads, valid_data stays 1, no overrun.
  - Frame completion while valid_data=1 and data_ready=0 -> old word kept, new word dropped, overrun pulses one clk.
- The error flags are meaningful only while valid_data=1 and change only on load.

Optional Feature:
UART_RX_PARITY_EN:
- Defined: PARITY state present, one parity bit after data. Expected parity: XOR of data bits, inverted if PARITY_ODD=1. Mismatch sets parity_error with the word; the frame is still delivered.
- Undefined: no PARITY state, frame goes DATA -> STOP, parity_error tied 0, PARITY_ODD ignored.

Decomposition:
- Package uart_pkg: FSM state enum (uart_rx_state_t), localparams for mid-sample tick offsets, bit-counter width via $clog2(DATA_BITS+1), tick-counter width via $clog2(OVERSAMPLE).
- Sub-module uart_rx_sampler: 2-flop synchroniser plus 3-sample majority voter. Outputs the synchronised line and the voted bit. Instantiated once.

Test Plan:
All cases use OVERSAMPLE=16 with baud_rate_signal high every clk unless stated.
1. Frame 0xA5, 8N1, data_ready=1 -> valid_data one clk, data=8'hA5, no error flags, busy falls after the stop-bit sample.
2. Start-bit glitch: line low for 4 ticks then high -> no valid_data, FSM back to IDLE; a following 0x3C frame is received correctly.
3. Back-to-back 0x11 then 0x22 with data_ready=0 -> data=0x11 retained, overrun pulses once. Raise data_ready -> valid clears. Repeat with data_ready pulsed on the completing clk -> 0x22 loaded, no overrun.
4. Stop bit low with data 0x00, line then held low 40 bit-times -> exactly one word 0x00 with framing_error=1. The next 0x55 is delivered only after the line returns high.
5. UART_RX_PARITY_EN, PARITY_ODD=0, frame 0x07 with parity bit 0 -> data=0x07, parity_error=1. Same frame with parity bit 1 -> parity_error=0.
6. Reset asserted mid-DATA of 0xFF, released between frames -> all outputs 0 during reset, no partial word; next frame 0x81 received correctly.
